proj_tt_sweeper: RTL and testbench

//   Sequencer for a shared, externally instantiated projected-function evaluator
//   (24-input x0..x23 -> y0 netlist that really depends on only 3 inputs).
//   On request, it drives all 8 combinations of the 3 projection inputs on top
//   of a latched 24-bit base vector and captures the evaluator output.
//   It returns the 8-entry truth table and a match flag against an expected

---
 rtl/proj_tt_sweeper.sv | 131 +++++++++++++
 tb/tb_proj_tt_sweeper.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_tt_sweeper.sv
// Sweeps the three projection inputs of an external evaluator over a latched base
// vector, captures the 8-entry truth table and compares it with an expected table.
module proj_tt_sweeper #(
  parameter int IDX0     = 1,
  parameter int IDX1     = 2,
  parameter int IDX2     = 3,
  parameter int EVAL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] base_vec,
  input  logic [7:0]  exp_tt,
  output logic [23:0] eval_x,
  input  logic        eval_y,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tt,
  output logic        match
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [23:0] base_q;
  logic [7:0]  exp_q;
  logic        accept;
  logic        issuing;
  logic        cap_vld;
  logic [2:0]  cap_idx;
  logic        pend;

  if (IDX0 == IDX1 || IDX0 == IDX2 || IDX1 == IDX2) begin : g_idx_overlap
    $error("proj_tt_sweeper: IDX0/IDX1/IDX2 must be distinct");
  end
  if (IDX0 < 0 || IDX0 > 23 || IDX1 < 0 || IDX1 > 23 || IDX2 < 0 || IDX2 > 23) begin : g_idx_range
    $error("proj_tt_sweeper: IDX parameters must lie in 0..23");
  end
  if (EVAL_LAT < 0 || EVAL_LAT > 4) begin : g_lat_range
    $error("proj_tt_sweeper: EVAL_LAT must lie in 0..4");
  end

  function automatic logic [23:0] sweep_pattern(input logic [23:0] base, input logic [2:0] i);
    logic [23:0] x;
    x       = base;
    x[IDX0] = i[0];
    x[IDX1] = i[1];
    x[IDX2] = i[2];
    return x;
  endfunction

  assign accept  = (state == IDLE) && start;
  assign issuing = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (cnt == 3'd7) state_nxt = DRAIN;
      DRAIN:   if (!pend) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Tag delay line: the index emerging at its tail is the one eval_y answers now.
  if (EVAL_LAT == 0) begin : g_comb_eval
    assign cap_vld = issuing;
    assign cap_idx = cnt;
    assign pend    = 1'b0;
  end else begin : g_pipe_eval
    logic [EVAL_LAT-1:0] vld_p;
    logic [2:0]          idx_p [EVAL_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= '0;
        for (int k = 0; k < EVAL_LAT; k++) idx_p[k] <= 3'd0;
      end else begin
        vld_p[0] <= issuing;
        idx_p[0] <= cnt;
        for (int k = 1; k < EVAL_LAT; k++) begin
          vld_p[k] <= vld_p[k-1];
          idx_p[k] <= idx_p[k-1];
        end
      end
    end

    assign cap_vld = vld_p[EVAL_LAT-1];
    assign cap_idx = idx_p[EVAL_LAT-1];
    assign pend    = |vld_p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 3'd0;
      base_q <= '0;
      exp_q  <= '0;
      eval_x <= '0;
      tt     <= '0;
      match  <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= base_vec;
        exp_q  <= exp_tt;
        tt     <= '0;
        cnt    <= 3'd0;
        eval_x <= sweep_pattern(base_vec, 3'd0);
      end else if (issuing && cnt != 3'd7) begin
        cnt    <= cnt + 3'd1;
        eval_x <= sweep_pattern(base_q, cnt + 3'd1);
      end
      if (cap_vld) tt[cap_idx] <= eval_y;
      // Delay line empty means tt already holds its final value.
      if (state == DRAIN && !pend) match <= (tt == exp_q);
    end
  end

endmodule

// File: tb/tb_proj_tt_sweeper.sv
// Bench for proj_tt_sweeper: a combinational-evaluator instance and a 3-cycle
// pipelined-evaluator instance, with a scoreboard of expected tables per instance.
module tb_proj_tt_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start3;
  logic [23:0] base0, base3;
  logic [7:0]  exp0, exp3;
  logic [23:0] ex0, ex3;
  logic        y0, y3;
  logic        busy0, busy3, done0, done3, m0, m3;
  logic [7:0]  tt0, tt3;
  logic [2:0]  ydly;

  typedef struct {
    logic [7:0] tt;
    logic       m;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic model_y(input logic [23:0] x);
    return ~(x[2] ? x[1] : x[3]);
  endfunction

  function automatic logic [23:0] pattern(input logic [23:0] base, input int i);
    logic [23:0] x;
    logic [2:0]  b;
    b    = i[2:0];
    x    = base;
    x[1] = b[0];
    x[2] = b[1];
    x[3] = b[2];
    return x;
  endfunction

  function automatic logic [7:0] model_tt(input logic [23:0] base);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = model_y(pattern(base, i));
    return t;
  endfunction

  proj_tt_sweeper #(.IDX0(1), .IDX1(2), .IDX2(3), .EVAL_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base_vec(base0), .exp_tt(exp0),
    .eval_x(ex0), .eval_y(y0), .busy(busy0), .done(done0), .tt(tt0), .match(m0)
  );

  proj_tt_sweeper #(.IDX0(1), .IDX1(2), .IDX2(3), .EVAL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .base_vec(base3), .exp_tt(exp3),
    .eval_x(ex3), .eval_y(y3), .busy(busy3), .done(done3), .tt(tt3), .match(m3)
  );

  assign y0 = model_y(ex0);
  always @(posedge clk) ydly <= {ydly[1:0], model_y(ex3)};
  assign y3 = ydly[2];

  always @(negedge clk) begin
    if (done0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_done: done seen with no sweep outstanding, tt=%h", tt0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        checks++;
        if (tt0 !== e.tt || m0 !== e.m) begin
          errors++;
          $display("FAIL dut0_result: got tt=%h match=%b, expected tt=%h match=%b", tt0, m0, e.tt, e.m);
        end
      end
    end
    if (done3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL dut3_unexpected_done: done seen with no sweep outstanding, tt=%h", tt3);
      end else begin
        exp_t e;
        e = q3.pop_front();
        checks++;
        if (tt3 !== e.tt || m3 !== e.m) begin
          errors++;
          $display("FAIL dut3_result: got tt=%h match=%b, expected tt=%h match=%b", tt3, m3, e.tt, e.m);
        end
      end
    end
  end

  task automatic sweep0(input logic [23:0] base, input logic [7:0] expv, input bit toggle, input string name);
    exp_t e;
    int   k;
    bit   got;
    e.tt = model_tt(base);
    e.m  = (e.tt == expv);
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b1; base0 = base; exp0 = expv;
    @(negedge clk);
    start0 = 1'b0;
    k = 1; got = 1'b0;
    while (!got && k <= 40) begin
      if (k <= 8) begin
        checks++;
        if (ex0 !== pattern(base, k - 1)) begin
          errors++;
          $display("FAIL %s_eval_x idx %0d: got %h expected %h", name, k - 1, ex0, pattern(base, k - 1));
        end
      end
      if (done0) begin
        got = 1'b1;
        checks++;
        if (k != 10 || busy0 !== 1'b1) begin
          errors++;
          $display("FAIL %s_done_timing: done at E+%0d busy=%b, expected E+10 busy=1", name, k, busy0);
        end
      end else begin
        if (toggle) begin base0 = ~base0; exp0 = ~exp0; end
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no done within 40 cycles, expected at E+10", name);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_fall: busy=%b after done, expected 0", name, busy0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0;
    base0 = '0; base3 = '0; exp0 = '0; exp3 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0, tt0, m0, ex0} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut0: busy=%b done=%b tt=%h match=%b eval_x=%h, expected all 0", busy0, done0, tt0, m0, ex0);
    end
    checks++;
    if ({busy3, done3, tt3, m3, ex3} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut3: busy=%b done=%b tt=%h match=%b eval_x=%h, expected all 0", busy3, done3, tt3, m3, ex3);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || ex0 !== 24'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b eval_x=%h, expected 0/0", busy0, ex0);
    end
  endtask

  task automatic test_match();
    sweep0(24'h000000, 8'h47, 1'b0, "match");
  endtask

  task automatic test_mismatch();
    sweep0(24'h000000, 8'h46, 1'b0, "mismatch");
  endtask

  task automatic test_latched();
    sweep0(24'h000000, 8'h47, 1'b1, "latched");
  endtask

  task automatic test_lat3();
    exp_t        e;
    int          k;
    bit          got;
    logic [23:0] base;
    base = 24'hFFFFF1;
    e.tt = model_tt(base);
    e.m  = (e.tt == 8'h47);
    q3.push_back(e);
    @(negedge clk);
    start3 = 1'b1; base3 = base; exp3 = 8'h47;
    @(negedge clk);
    start3 = 1'b0;
    k = 1; got = 1'b0;
    while (!got && k <= 40) begin
      checks++;
      if (ex3 !== pattern(base, (k <= 8) ? k - 1 : 7) || ex3[23:4] !== 20'hFFFFF || ex3[0] !== 1'b1) begin
        errors++;
        $display("FAIL lat3_eval_x at E+%0d: got %h expected %h", k, ex3, pattern(base, (k <= 8) ? k - 1 : 7));
      end
      if (done3) begin
        got = 1'b1;
        checks++;
        if (k != 13) begin
          errors++;
          $display("FAIL lat3_done_timing: done at E+%0d, expected E+13", k);
        end
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL lat3_timeout: no done within 40 cycles, expected at E+13");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    e.tt = model_tt(24'h0);
    e.m  = (e.tt == 8'h47);
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b1; base0 = 24'h0; exp0 = 8'h47;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b at E+10, expected 1", done0);
    end
    start0 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_cycle_start: busy=%b after DONE, expected 0", busy0);
    end
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || ex0 !== pattern(24'h0, 0)) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b eval_x=%h, expected 1/%h", busy0, ex0, pattern(24'h0, 0));
    end
    n = 1;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL b2b_second_done: done at E+%0d, expected E+10", n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    e.tt = model_tt(24'h0);
    e.m  = 1'b1;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b1; base0 = 24'h0; exp0 = 8'h47;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, tt0, m0, ex0} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b done=%b tt=%h match=%b eval_x=%h, expected all 0", busy0, done0, tt0, m0, ex0);
    end
    checks++;
    if (tt3 !== 8'd0 || m3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dut3: tt=%h match=%b, expected 0/0", tt3, m3);
    end
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || tt0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b tt=%h, expected 0/00", busy0, tt0);
    end
    sweep0(24'h000000, 8'h47, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_lat3();
    test_back_to_back();
    test_reset_mid();
    test_latched();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d sweeps still outstanding, expected 0/0", q0.size(), q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
